// File: rtl/xbar_switch_alloc.sv
// xbar_switch_alloc: registered round-robin switch allocator for the 6-port router crossbar.
// Define XBAR_ALLOC_LOCK_EN to hold an output for a whole packet (wormhole lock).
module xbar_switch_alloc #(
  parameter int NUM_PORT     = 6,
  parameter int LOG_NUM_PORT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORT*NUM_PORT-1:0] reqVector,
  input  logic [NUM_PORT-1:0]          tailVector,
  input  logic [NUM_PORT-1:0]          outReady,
  output logic [NUM_PORT*NUM_PORT-1:0] allocVector,
  output logic [NUM_PORT-1:0]          grantVector
);

  localparam logic [LOG_NUM_PORT:0]   PORT_CNT = (LOG_NUM_PORT+1)'(NUM_PORT);
  localparam logic [LOG_NUM_PORT-1:0] LAST_IDX = LOG_NUM_PORT'(NUM_PORT - 1);

  logic [NUM_PORT-1:0]          maskedReq [NUM_PORT];
  logic [NUM_PORT-1:0]          eligible  [NUM_PORT];  // eligible[output][input]
  logic [LOG_NUM_PORT-1:0]      ptrQ      [NUM_PORT];
  logic [LOG_NUM_PORT-1:0]      ptrNext   [NUM_PORT];
  logic [NUM_PORT*NUM_PORT-1:0] allocNext;
  logic [NUM_PORT-1:0]          grantNext;

`ifdef XBAR_ALLOC_LOCK_EN
  logic [NUM_PORT-1:0]     lockValidQ;
  logic [NUM_PORT-1:0]     lockValidNext;
  logic [LOG_NUM_PORT-1:0] lockOwnerQ    [NUM_PORT];
  logic [LOG_NUM_PORT-1:0] lockOwnerNext [NUM_PORT];
`else
  logic unusedTail;
  assign unusedTail = ^tailVector;
`endif

  function automatic logic [LOG_NUM_PORT-1:0] nextPtr(input logic [LOG_NUM_PORT-1:0] p);
    return (p == LAST_IDX) ? {LOG_NUM_PORT{1'b0}} : p + LOG_NUM_PORT'(1);
  endfunction

  // Keep only the lowest-index output requested by each input row
  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) begin
      maskedReq[i] = reqVector[i*NUM_PORT +: NUM_PORT]
                   & (~reqVector[i*NUM_PORT +: NUM_PORT] + {{(NUM_PORT-1){1'b0}}, 1'b1});
    end
  end

  // Per-output eligibility: masked request, downstream ready, and lock ownership
  always_comb begin
    for (int j = 0; j < NUM_PORT; j++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
`ifdef XBAR_ALLOC_LOCK_EN
        eligible[j][i] = maskedReq[i][j] & outReady[j]
                       & (~lockValidQ[j] | (lockOwnerQ[j] == LOG_NUM_PORT'(i)));
`else
        eligible[j][i] = maskedReq[i][j] & outReady[j];
`endif
      end
    end
  end

  // Round-robin pick per output plus next pointer / lock state
  always_comb begin
    logic                    found;
    logic                    hit;
    logic [LOG_NUM_PORT:0]   sum;
    logic [LOG_NUM_PORT:0]   wrapped;
    logic [LOG_NUM_PORT-1:0] winIdx;
    found     = 1'b0;
    hit       = 1'b0;
    sum       = '0;
    wrapped   = '0;
    winIdx    = '0;
    allocNext = '0;
    grantNext = '0;
    ptrNext   = ptrQ;
`ifdef XBAR_ALLOC_LOCK_EN
    lockValidNext = lockValidQ;
    lockOwnerNext = lockOwnerQ;
`endif
    for (int j = 0; j < NUM_PORT; j++) begin
      found  = |eligible[j];
      winIdx = '0;
      // Scan offsets downward so the candidate nearest the pointer is taken last
      for (int off = NUM_PORT - 1; off >= 0; off--) begin
        sum     = {1'b0, ptrQ[j]} + (LOG_NUM_PORT+1)'(off);
        wrapped = (sum >= PORT_CNT) ? sum - PORT_CNT : sum;
        winIdx  = eligible[j][wrapped[LOG_NUM_PORT-1:0]] ? wrapped[LOG_NUM_PORT-1:0] : winIdx;
      end
      for (int i = 0; i < NUM_PORT; i++) begin
        hit                     = found & (winIdx == LOG_NUM_PORT'(i));
        allocNext[i*NUM_PORT+j] = hit;
        grantNext[i]            = grantNext[i] | hit;
      end
      if (found) begin
`ifdef XBAR_ALLOC_LOCK_EN
        lockOwnerNext[j] = winIdx;
        lockValidNext[j] = ~tailVector[winIdx];
        ptrNext[j]       = tailVector[winIdx] ? nextPtr(winIdx) : ptrQ[j];
`else
        ptrNext[j] = nextPtr(winIdx);
`endif
      end else begin
        ptrNext[j] = ptrQ[j];
      end
    end
  end

  // Output and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      allocVector <= '0;
      grantVector <= '0;
      for (int j = 0; j < NUM_PORT; j++) begin
        ptrQ[j] <= '0;
      end
    end else begin
      allocVector <= allocNext;
      grantVector <= grantNext;
      ptrQ        <= ptrNext;
    end
  end

`ifdef XBAR_ALLOC_LOCK_EN
  // Wormhole lock registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lockValidQ <= '0;
      for (int j = 0; j < NUM_PORT; j++) begin
        lockOwnerQ[j] <= '0;
      end
    end else begin
      lockValidQ <= lockValidNext;
      lockOwnerQ <= lockOwnerNext;
    end
  end
`endif

endmodule

// File: tb/tb_xbar_switch_alloc.sv
// Scoreboard bench for xbar_switch_alloc: a reference model pushes expected outputs
// when inputs are driven; they are popped and compared one cycle later.
module tb_xbar_switch_alloc;
  localparam int NP = 6;
`ifdef XBAR_ALLOC_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*NP-1:0] reqVector;
  logic [NP-1:0]    tailVector;
  logic [NP-1:0]    outReady;
  logic [NP*NP-1:0] allocVector;
  logic [NP-1:0]    grantVector;

  int errCount   = 0;
  int checkCount = 0;

  logic [NP*NP-1:0] allocQ [$];
  logic [NP-1:0]    grantQ [$];

  int          mPtr      [NP];
  bit          mLockV    [NP];
  int          mLockO    [NP];
  logic [NP-1:0] rowMask [NP];
  int          flitsLeft [NP];
  bit          alwaysTail[NP];

  logic [NP-1:0] whSeq [5];
  logic [NP-1:0] ctSeq [4];

  xbar_switch_alloc dut (
    .clk        (clk),
    .reset      (reset),
    .reqVector  (reqVector),
    .tailVector (tailVector),
    .outReady   (outReady),
    .allocVector(allocVector),
    .grantVector(grantVector)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [NP*NP-1:0] got, input logic [NP*NP-1:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NP; i++) begin
      mPtr[i]       = 0;
      mLockV[i]     = 1'b0;
      mLockO[i]     = 0;
      rowMask[i]    = '0;
      flitsLeft[i]  = 0;
      alwaysTail[i] = 1'b0;
    end
  endtask

  task automatic driveInputs();
    reqVector  = '0;
    tailVector = '0;
    for (int i = 0; i < NP; i++) begin
      if (flitsLeft[i] > 0) begin
        reqVector[i*NP +: NP] = rowMask[i];
        tailVector[i]         = alwaysTail[i] || (flitsLeft[i] == 1);
      end
    end
  endtask

  task automatic modelStep(output logic [NP*NP-1:0] ea, output logic [NP-1:0] eg);
    int low [NP];
    int best;
    int bestD;
    int d;
    bit rel;
    ea = '0;
    eg = '0;
    for (int i = 0; i < NP; i++) begin
      low[i] = -1;
      for (int j = NP - 1; j >= 0; j--) begin
        if (reqVector[i*NP+j]) low[i] = j;
      end
    end
    for (int j = 0; j < NP; j++) begin
      best  = -1;
      bestD = NP;
      for (int i = 0; i < NP; i++) begin
        if (low[i] == j && outReady[j] && (!LOCK_ON || !mLockV[j] || mLockO[j] == i)) begin
          d = (i - mPtr[j] + NP) % NP;
          if (d < bestD) begin
            bestD = d;
            best  = i;
          end
        end
      end
      if (best >= 0) begin
        ea[best*NP+j] = 1'b1;
        eg[best]      = 1'b1;
        rel = LOCK_ON ? tailVector[best] : 1'b1;
        if (rel) begin
          mPtr[j]   = (best + 1) % NP;
          mLockV[j] = 1'b0;
        end else begin
          mLockV[j] = 1'b1;
          mLockO[j] = best;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    logic [NP*NP-1:0] ea;
    logic [NP-1:0]    eg;
    driveInputs();
    modelStep(ea, eg);
    allocQ.push_back(ea);
    grantQ.push_back(eg);
    @(posedge clk);
    #1;
    ea = allocQ.pop_front();
    eg = grantQ.pop_front();
    checkVal({tag, "_alloc"}, allocVector, ea);
    checkVal({tag, "_grant"}, {30'd0, grantVector}, {30'd0, eg});
    for (int i = 0; i < NP; i++) begin
      if (eg[i] && flitsLeft[i] > 0) flitsLeft[i]--;
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    clearModel();
    reqVector  = '0;
    tailVector = '0;
    outReady   = '1;
    @(posedge clk);
    #1;
    checkVal("rst_alloc", allocVector, 36'h0);
    checkVal("rst_grant", {30'd0, grantVector}, 36'h0);
    reset = 1'b0;
  endtask

  initial begin
`ifdef XBAR_ALLOC_LOCK_EN
    whSeq = '{6'b000010, 6'b000010, 6'b000010, 6'b010000, 6'b010000};
`else
    whSeq = '{6'b000010, 6'b010000, 6'b000010, 6'b010000, 6'b000010};
`endif
    ctSeq = '{6'b000001, 6'b001000, 6'b100000, 6'b000001};

    // Reset then idle, including the first cycle after release
    doReset();
    for (int k = 0; k < 3; k++) step("idle");

    // Single request 2 -> 4, then prove ptr[4] moved to 3 via a 2-vs-3 contest
    doReset();
    rowMask[2] = 6'b010000; flitsLeft[2] = 1;
    step("single");
    checkVal("single_bit16", allocVector, 36'h0_0001_0000);
    checkVal("single_gv", {30'd0, grantVector}, {30'd0, 6'b000100});
    rowMask[2] = 6'b010000; flitsLeft[2] = 1;
    rowMask[3] = 6'b010000; flitsLeft[3] = 1;
    step("ptr4");
    checkVal("ptr4_winner3", {30'd0, grantVector}, {30'd0, 6'b001000});
    step("ptr4_rest");

    // Contention on output 1 from inputs 0, 3, 5 with single-flit packets
    doReset();
    for (int i = 0; i < NP; i += 1) begin
      if (i == 0 || i == 3 || i == 5) begin
        rowMask[i] = 6'b000010; alwaysTail[i] = 1'b1;
        flitsLeft[i] = (i == 0) ? 2 : 1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      step("contend");
      checkVal("contend_seq", {30'd0, grantVector}, {30'd0, ctSeq[k]});
    end

    // Wormhole: input 1 (3 flits) vs input 4 (2 flits) on output 2
    doReset();
    rowMask[1] = 6'b000100; flitsLeft[1] = 3;
    rowMask[4] = 6'b000100; flitsLeft[4] = 2;
    for (int k = 0; k < 5; k++) begin
      step("worm");
      checkVal("worm_seq", {30'd0, grantVector}, {30'd0, whSeq[k]});
    end

    // Backpressure on output 3
    doReset();
    outReady = 6'b110111;
    rowMask[0] = 6'b001000; flitsLeft[0] = 1; alwaysTail[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step("bp_hold");
      checkVal("bp_nogrant", {30'd0, grantVector}, 36'h0);
    end
    outReady = '1;
    step("bp_go");
    checkVal("bp_alloc", allocVector, 36'h0_0000_0008);

    // Multi-bit request, then reset in the middle of the packet
    doReset();
    rowMask[5] = 6'b000110; flitsLeft[5] = 3;
    step("multi");
    checkVal("multi_lowest", allocVector, 36'h0_8000_0000);
    step("multi2");
    reset = 1'b1;
    #1;
    checkVal("midrst_alloc", allocVector, 36'h0);
    checkVal("midrst_grant", {30'd0, grantVector}, 36'h0);
    clearModel();
    reqVector  = '0;
    tailVector = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst");
    rowMask[2] = 6'b000010; flitsLeft[2] = 1;
    step("lock_clear");
    checkVal("lock_clear_alloc", allocVector, 36'h0_0000_2000);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
